// File: rtl/axis_image_vip_pkg.sv
// Shared definitions for the image VIP stream blocks: default beat widths
// and the byte-lane keep helper used by the width converters.
package axis_image_vip_pkg;

    localparam int SOURCE_BYTES  = 1;
    localparam int SINK_BYTES    = 4;
    localparam int MAX_OUT_BYTES = 256;

    // Keep pattern for a single lane: IN_BYTES ones starting at byte cnt*IN_BYTES.
    function automatic logic [MAX_OUT_BYTES-1:0] lane_mask(input int cnt,
                                                          input int inBytes,
                                                          input int ratio);
        logic [MAX_OUT_BYTES-1:0] mask;
        mask = '0;
        if (cnt >= 0 && cnt < ratio) begin
            for (int b = 0; b < MAX_OUT_BYTES; b++) begin
                if (b >= cnt * inBytes && b < (cnt + 1) * inBytes) begin
                    mask[b] = 1'b1;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_beat_packer_if.sv
// Bundles both stream sides of the packer; slave is the packer's view,
// master is the view of the environment that feeds and drains it.
interface axis_beat_packer_if #(
    parameter int IN_BYTES = 1,
    parameter int RATIO    = 4
) ();

    localparam int IN_BITS   = IN_BYTES * 8;
    localparam int OUT_BYTES = IN_BYTES * RATIO;
    localparam int OUT_BITS  = OUT_BYTES * 8;

    logic [IN_BITS-1:0]   s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 s_last;
    logic [OUT_BITS-1:0]  m_data;
    logic [OUT_BYTES-1:0] m_keep;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_keep, m_valid, m_last
    );

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_keep, m_valid, m_last
    );

endinterface

// File: rtl/axis_beat_packer_out_reg.sv
// Single-entry registered output slot; a load always wins over a drain so
// back-to-back words flow without a bubble.
module axis_out_reg #(
    parameter int DATA_BITS = 32,
    parameter int KEEP_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic [KEEP_BITS-1:0] keep_i,
    input  logic                 last_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic [KEEP_BITS-1:0] keep_o,
    output logic                 last_o
);

    logic                 valid_q;
    logic [DATA_BITS-1:0] data_q;
    logic [KEEP_BITS-1:0] keep_q;
    logic                 last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            keep_q  <= keep_i;
            last_q  <= last_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: rtl/axis_beat_packer.sv
// Packs RATIO narrow stream beats into one wide beat; tlast flushes a
// partial word early with only the filled lanes marked in keep.
module axis_beat_packer
    import axis_image_vip_pkg::*;
#(
    parameter int IN_BYTES = SOURCE_BYTES,
    parameter int RATIO    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    axis_beat_packer_if.slave  bus
);

    localparam int IN_BITS   = IN_BYTES * 8;
    localparam int OUT_BYTES = IN_BYTES * RATIO;
    localparam int OUT_BITS  = OUT_BYTES * 8;
    localparam int CNT_W     = $clog2(RATIO);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_BITS-1:0]  accData_q, accData_d, wordData;
    logic [OUT_BYTES-1:0] accKeep_q, accKeep_d, wordKeep;
    logic                 accept, complete, outValid;

    // Ready depends only on the output slot, never on the incoming beat.
    assign bus.s_ready = !outValid || bus.m_ready;
    assign accept      = bus.s_valid && bus.s_ready;
    assign complete    = accept && ((cnt_q == CNT_W'(RATIO - 1)) || bus.s_last);

    always_comb begin
        wordData = accData_q;
        wordData[int'(cnt_q) * IN_BITS +: IN_BITS] = bus.s_data;
        wordKeep = accKeep_q | OUT_BYTES'(lane_mask(int'(cnt_q), IN_BYTES, RATIO));
        cnt_d     = cnt_q;
        accData_d = accData_q;
        accKeep_d = accKeep_q;
        if (accept) begin
            if (complete) begin
                cnt_d     = '0;
                accData_d = '0;
                accKeep_d = '0;
            end else begin
                cnt_d     = cnt_q + CNT_W'(1);
                accData_d = wordData;
                accKeep_d = wordKeep;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            accData_q <= '0;
            accKeep_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            accData_q <= accData_d;
            accKeep_q <= accKeep_d;
        end
    end

    axis_out_reg #(
        .DATA_BITS (OUT_BITS),
        .KEEP_BITS (OUT_BYTES)
    ) outReg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (complete),
        .data_i  (wordData),
        .keep_i  (wordKeep),
        .last_i  (bus.s_last),
        .ready_i (bus.m_ready),
        .valid_o (outValid),
        .data_o  (bus.m_data),
        .keep_o  (bus.m_keep),
        .last_o  (bus.m_last)
    );

    assign bus.m_valid = outValid;

endmodule

// File: tb/tb_axis_beat_packer.sv
// Directed and random stimulus for axis_beat_packer, checked every cycle
// against a frame-level byte packing model plus literal expected words.
module tb_axis_beat_packer;

    localparam int IN_BYTES = 1;
    localparam int RATIO    = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    axis_beat_packer_if #(.IN_BYTES(IN_BYTES), .RATIO(RATIO)) bus ();

    axis_beat_packer #(.IN_BYTES(IN_BYTES), .RATIO(RATIO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    logic [7:0]  frameBytes[$];
    word_t       expQ[$];
    word_t       lastBuilt;
    logic        latencyPending = 1'b0;
    logic        prevStall = 1'b0;
    logic [36:0] prevWord;
    int          outCount = 0;
    logic [31:0] gotData;
    logic [3:0]  gotKeep;
    logic        gotLast;
    logic        watchReady = 1'b0;
    logic        readyDropped = 1'b0;
    logic        randomReady = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Model: collect the bytes of the current frame; a word is due once RATIO bytes are held or last arrives.
    always @(negedge clk) begin
        if (rst) begin
            frameBytes.delete();
            expQ.delete();
            latencyPending = 1'b0;
            prevStall = 1'b0;
        end else begin
            if (latencyPending) begin
                checkOutput("latency valid", bus.m_valid, 1'b1);
                checkOutput("latency data", bus.m_data, lastBuilt.data);
                latencyPending = 1'b0;
            end
            if (prevStall) begin
                checkOutput("stall hold", {bus.m_data, bus.m_keep, bus.m_last}, prevWord);
            end
            checkOutput("s_ready rule", bus.s_ready, !bus.m_valid || bus.m_ready);
            if (watchReady && !bus.s_ready) readyDropped = 1'b1;
            if (bus.m_valid && bus.m_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected output", 1'b1, 1'b0);
                end else begin
                    word_t e;
                    e = expQ.pop_front();
                    checkOutput("out data", bus.m_data, e.data);
                    checkOutput("out keep", bus.m_keep, e.keep);
                    checkOutput("out last", bus.m_last, e.last);
                end
                outCount++;
                gotData = bus.m_data;
                gotKeep = bus.m_keep;
                gotLast = bus.m_last;
            end
            prevStall = bus.m_valid && !bus.m_ready;
            prevWord  = {bus.m_data, bus.m_keep, bus.m_last};
            if (bus.s_valid && bus.s_ready) begin
                frameBytes.push_back(bus.s_data);
                if (frameBytes.size() == RATIO || bus.s_last) begin
                    word_t w;
                    w.data = '0;
                    for (int i = 0; i < frameBytes.size(); i++) w.data[8*i +: 8] = frameBytes[i];
                    w.keep = 4'((1 << frameBytes.size()) - 1);
                    w.last = bus.s_last;
                    expQ.push_back(w);
                    lastBuilt = w;
                    latencyPending = 1'b1;
                    frameBytes.delete();
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (randomReady) bus.m_ready = 1'($urandom_range(0, 1));
    end

    task automatic applyStimulus(input logic [7:0] d, input logic l);
        logic accepted;
        int n;
        accepted = 1'b0;
        n = 0;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        while (!accepted && n < 200) begin
            @(negedge clk);
            accepted = bus.s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!accepted) checkOutput("input timeout", 1'b0, 1'b1);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic waitOutputs(input int target);
        int n;
        n = 0;
        while (outCount < target && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("output timeout", outCount >= target, 1'b1);
    endtask

    task automatic pulseReset();
        #2 rst = 1'b1;
        #1;
        checkOutput("reset valid", bus.m_valid, 1'b0);
        checkOutput("reset keep", bus.m_keep, 4'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int startCycle;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset m_valid", bus.m_valid, 1'b0);
        checkOutput("reset m_data", bus.m_data, 32'h0);
        checkOutput("reset m_keep", bus.m_keep, 4'h0);
        checkOutput("reset m_last", bus.m_last, 1'b0);
        checkOutput("reset s_ready", bus.s_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full word, back to back
        base = outCount;
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        checkOutput("t1 valid after 1 cycle", bus.m_valid, 1'b1);
        waitOutputs(base + 1);
        checkOutput("t1 data", gotData, 32'h44332211);
        checkOutput("t1 keep", gotKeep, 4'hF);
        checkOutput("t1 last", gotLast, 1'b0);

        // Early flush on last
        base = outCount;
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'hA2, 1'b1);
        waitOutputs(base + 1);
        checkOutput("t2 data", gotData, 32'h0000A2A1);
        checkOutput("t2 keep", gotKeep, 4'h3);
        checkOutput("t2 last", gotLast, 1'b1);

        // Twelve streamed beats without a bubble
        base = outCount;
        startCycle = cycle;
        watchReady = 1'b1;
        for (int i = 0; i < 12; i++) applyStimulus(8'(8'h30 + i), 1'b0);
        watchReady = 1'b0;
        checkOutput("t3 cycles", cycle - startCycle, 12);
        checkOutput("t3 s_ready drop", readyDropped, 1'b0);
        waitOutputs(base + 3);
        checkOutput("t3 data", gotData, 32'h3B3A3938);

        // Stalled sink
        base = outCount;
        bus.m_ready = 1'b0;
        applyStimulus(8'h55, 1'b0);
        applyStimulus(8'h56, 1'b0);
        applyStimulus(8'h57, 1'b0);
        applyStimulus(8'h58, 1'b1);
        repeat (6) begin
            @(negedge clk);
            checkOutput("t4 stall valid", bus.m_valid, 1'b1);
            checkOutput("t4 stall s_ready", bus.s_ready, 1'b0);
            checkOutput("t4 stall data", bus.m_data, 32'h58575655);
        end
        checkOutput("t4 stall last", bus.m_last, 1'b1);
        @(posedge clk);
        #1 bus.m_ready = 1'b1;
        waitOutputs(base + 1);
        checkOutput("t4 drained data", gotData, 32'h58575655);
        applyStimulus(8'h59, 1'b0);
        applyStimulus(8'h5A, 1'b0);
        applyStimulus(8'h5B, 1'b0);
        applyStimulus(8'h5C, 1'b0);
        waitOutputs(base + 2);
        checkOutput("t4 next data", gotData, 32'h5C5B5A59);
        checkOutput("t4 no duplicate", outCount, base + 2);

        // Reset with a pending output word, then mid-frame
        bus.m_ready = 1'b0;
        applyStimulus(8'hD1, 1'b0);
        applyStimulus(8'hD2, 1'b1);
        checkOutput("t5 pending valid", bus.m_valid, 1'b1);
        pulseReset();
        bus.m_ready = 1'b1;
        applyStimulus(8'hB1, 1'b0);
        applyStimulus(8'hB2, 1'b0);
        pulseReset();
        base = outCount;
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h04, 1'b0);
        waitOutputs(base + 1);
        checkOutput("t5 data", gotData, 32'h04030201);
        checkOutput("t5 keep", gotKeep, 4'hF);
        checkOutput("t5 count", outCount, base + 1);

        // Random traffic
        randomReady = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            applyStimulus(8'($urandom_range(0, 255)), (i == 999) || ($urandom_range(0, 4) == 0));
        end
        randomReady = 1'b0;
        #2 bus.m_ready = 1'b1;
        for (int n = 0; n < 50 && expQ.size() != 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6 drained", expQ.size(), 0);
        checkOutput("t6 no partial", frameBytes.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
